// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM,
// one-cycle rx_valid / frame_err strobes and a held rx_data byte.
module uart_rx #(
  parameter int unsigned clk_rate  = 100_000_000,
  parameter int unsigned baud_rate = 115_200,
  parameter int unsigned clk_div   = clk_rate / baud_rate
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [15:0] half_last = 16'(clk_div / 2 - 1);
  localparam logic [15:0] bit_last  = 16'(clk_div - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_busy_q, rx_busy_d;
  logic        rx_meta_q, rx_sync_q;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_sync_q) state_d = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (cnt_q == half_last) state_d = rx_sync_q ? IDLE : DATA;
      end
      DATA: begin
        if (cnt_q == bit_last) begin
          shift_d[idx_q] = rx_sync_q;
          cnt_d          = '0;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == bit_last) begin
          if (rx_sync_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
    rx_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop here samples pre-edge values.
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      // NOTE: the shift register is plain flops, so it is reset with the rest rather than left X.
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a frame-level timeline model (expected strobe edges,
// busy windows, held byte) compared against the DUT on every cycle.
module tb_uart_rx;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(.clk_rate(1600), .baud_rate(100)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model timeline: events land on the edge that registers them.
  typedef struct {int at; int kind; logic [7:0] data;} ev_t;   // kind 0 good, 1 ferr, 2 reset
  typedef struct {int lo; int hi;} iv_t;                        // busy after edges lo..hi-1
  typedef struct {int at; logic [7:0] data;} log_t;

  ev_t  ev_q[$];
  iv_t  iv_q[$];
  log_t valid_log[$];
  int   ferr_log[$];
  int   n_good = 0;

  logic [7:0] exp_data = 8'h00;
  logic       exp_valid, exp_ferr, exp_busy;
  logic       chk_en = 1'b0;
  ev_t        ev;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_valid = 1'b0;
      exp_ferr  = 1'b0;
      while (ev_q.size() != 0 && ev_q[0].at <= cyc) begin
        ev = ev_q.pop_front();
        if (ev.at == cyc) begin
          case (ev.kind)
            0:       begin exp_valid = 1'b1; exp_data = ev.data; end
            1:       exp_ferr = 1'b1;
            default: exp_data = 8'h00;
          endcase
        end
      end
      while (iv_q.size() != 0 && iv_q[0].hi <= cyc) void'(iv_q.pop_front());
      exp_busy = (iv_q.size() != 0) && (iv_q[0].lo <= cyc);

      check($sformatf("rx_valid@%0d", cyc), rx_valid, exp_valid);
      check($sformatf("frame_err@%0d", cyc), frame_err, exp_ferr);
      check($sformatf("rx_busy@%0d", cyc), rx_busy, exp_busy);
      check($sformatf("rx_data@%0d", cyc), rx_data, exp_data);

      if (rx_valid === 1'b1) valid_log.push_back('{cyc, rx_data});
      if (frame_err === 1'b1) ferr_log.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset(input int n);
    int a;
    a   = cyc;
    rst = 1'b1;
    while (ev_q.size() != 0 && ev_q[$].at >= a + 1) void'(ev_q.pop_back());
    ev_q.push_back('{a + 1, 2, 8'h00});
    foreach (iv_q[i]) if (iv_q[i].hi > a + 1) iv_q[i].hi = a + 1;
    tick(n);
    rst = 1'b0;
  endtask

  // Drives one frame starting now; the falling edge reaches the FSM 3 edges later (E).
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int hold_low, input int abort_bit);
    int c, e;
    logic [9:0] bits;
    c    = cyc;
    e    = c + 3;
    bits = {stop_bit, d, 1'b0};
    if (stop_bit) begin
      ev_q.push_back('{e + DIV / 2 + 9 * DIV, 0, d});
      iv_q.push_back('{e, e + DIV / 2 + 9 * DIV});
      if (abort_bit < 0) n_good++;
    end else begin
      ev_q.push_back('{e + DIV / 2 + 9 * DIV, 1, 8'h00});
      iv_q.push_back('{e, c + 10 * DIV + hold_low + 3});
    end
    for (int b = 0; b < 10; b++) begin
      rx = bits[b];
      if (abort_bit >= 0 && b == abort_bit + 1) begin
        tick(DIV / 2);
        rx = 1'b1;
        pulse_reset(2);
        return;
      end
      tick(DIV);
    end
    if (!stop_bit) begin
      rx = 1'b0;
      tick(hold_low);
      rx = 1'b1;
      tick(2);
    end
    rx = 1'b1;
  endtask

  task automatic glitch(input int len);
    int c;
    c = cyc;
    iv_q.push_back('{c + 3, c + 3 + DIV / 2});
    rx = 1'b0;
    tick(len);
    rx = 1'b1;
    tick(DIV - len);
  endtask

  int nv, nf, c0, k;
  logic [7:0] rd;

  initial begin
    rst    = 1'b1;
    rx     = 1'b1;
    chk_en = 1'b1;
    tick(3);
    rst = 1'b0;

    // Reset and quiet line.
    tick(200);
    check("t1_valid_count", valid_log.size(), 0);
    check("t1_ferr_count", ferr_log.size(), 0);
    check("t1_rx_data", rx_data, 8'h00);
    check("t1_busy", rx_busy, 1'b0);

    // Single frame with pinned strobe edge.
    nv = valid_log.size();
    c0 = cyc;
    send_frame(8'hA5, 1'b1, 0, -1);
    tick(4);
    check("t2_count", valid_log.size() - nv, 1);
    check("t2_edge", valid_log[nv].at - c0, 155);
    check("t2_data", valid_log[nv].data, 8'hA5);
    check("t2_busy_after", rx_busy, 1'b0);
    check("t2_no_ferr", ferr_log.size(), 0);

    // Back-to-back frames with one-bit stops.
    nv = valid_log.size();
    send_frame(8'h00, 1'b1, 0, -1);
    send_frame(8'hFF, 1'b1, 0, -1);
    tick(4);
    check("t3_count", valid_log.size() - nv, 2);
    check("t3_spacing", valid_log[nv + 1].at - valid_log[nv].at, 160);
    check("t3_data0", valid_log[nv].data, 8'h00);
    check("t3_data1", valid_log[nv + 1].data, 8'hFF);

    // Glitch then a good frame.
    nv = valid_log.size();
    glitch(5);
    tick(10);
    check("t4_glitch_no_valid", valid_log.size() - nv, 0);
    check("t4_glitch_no_ferr", ferr_log.size(), 0);
    send_frame(8'h3C, 1'b1, 0, -1);
    tick(4);
    check("t4_data", rx_data, 8'h3C);

    // Framing error, line held low, then recovery.
    nv = valid_log.size();
    nf = ferr_log.size();
    c0 = cyc;
    send_frame(8'h55, 1'b0, 64, -1);
    tick(16);
    check("t5_ferr_count", ferr_log.size() - nf, 1);
    check("t5_ferr_edge", ferr_log[nf] - c0, 155);
    check("t5_no_valid", valid_log.size() - nv, 0);
    check("t5_data_held", rx_data, 8'h3C);
    send_frame(8'h81, 1'b1, 0, -1);
    tick(4);
    check("t5_next_data", rx_data, 8'h81);

    // Reset during data bit 4.
    nv = valid_log.size();
    nf = ferr_log.size();
    send_frame(8'hC3, 1'b1, 0, 4);
    tick(200);
    check("t6_no_valid", valid_log.size() - nv, 0);
    check("t6_no_ferr", ferr_log.size() - nf, 0);
    check("t6_data_reset", rx_data, 8'h00);
    send_frame(8'h7E, 1'b1, 0, -1);
    tick(4);
    check("t6_next_data", rx_data, 8'h7E);

    // Randomised mix of good frames, glitches, framing errors and aborts.
    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 9);
      rd = 8'($urandom);
      case (k)
        0:       glitch($urandom_range(1, 6));
        1:       send_frame(rd, 1'b0, $urandom_range(0, 30), -1);
        2:       begin send_frame(rd, 1'b1, 0, $urandom_range(0, 7)); tick(4); end
        default: send_frame(rd, 1'b1, 0, -1);
      endcase
      tick($urandom_range(0, 20));
    end
    tick(200);
    check("total_good_frames", valid_log.size(), n_good);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
